// File: rtl/sipo_reg_if.sv
// Serial-in / parallel-out bus bundle.
// The master drives the serial bit stream.
// The slave (the shift register) returns the assembled word and its status.
interface sipo_reg_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                  en;
    logic                  serial_in;
    logic [DATA_WIDTH-1:0] parallel_out;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  word_done;

    modport master (
        output en,
        output serial_in,
        input  parallel_out,
        input  bit_cnt,
        input  word_done
    );

    modport slave (
        input  en,
        input  serial_in,
        output parallel_out,
        output bit_cnt,
        output word_done
    );
endinterface

// File: rtl/sipo_reg.sv
// Serial-in / parallel-out shift register with a word counter.
// word_done is a one-cycle registered pulse, raised after the last bit of each word.
// All outputs come straight from flops.
module sipo_reg #(
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    sipo_reg_if.slave    bus
);
    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic                  done_q,  done_d;

    // Next-state: shift in one bit per enabled cycle and wrap the counter at a full word.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (bus.en) begin
            if (LSB_FIRST) begin
                shift_d = {bus.serial_in, shift_q[DATA_WIDTH-1:1]};
            end else begin
                shift_d = {shift_q[DATA_WIDTH-2:0], bus.serial_in};
            end
            if (cnt_q == CNT_LAST) begin
                cnt_d  = {CNT_W{1'b0}};
                done_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                done_d = 1'b0;
            end
        end else begin
            shift_d = shift_q;
            cnt_d   = cnt_q;
            done_d  = 1'b0;
        end
    end

    // State registers.
    // Reset wins over en, so a bit presented during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= {DATA_WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.parallel_out = shift_q;
    assign bus.bit_cnt      = cnt_q;
    assign bus.word_done    = done_q;
endmodule

// File: tb/tb_sipo_reg.sv
// Directed and random checks of sipo_reg, using DATA_WIDTH=8.
// Two instances run side by side and share one input stream: one is LSB-first, the other MSB-first.
module tb_sipo_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic sin = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state for the random phase.
    logic [7:0] m_l   = 8'h00;
    logic [7:0] m_m   = 8'h00;
    logic [2:0] m_cnt = 3'd0;
    logic       m_dn  = 1'b0;

    always #5 clk = ~clk;

    sipo_reg_if #(.DATA_WIDTH(8)) if_l ();
    sipo_reg_if #(.DATA_WIDTH(8)) if_m ();

    assign if_l.en        = en;
    assign if_l.serial_in = sin;
    assign if_m.en        = en;
    assign if_m.serial_in = sin;

    sipo_reg #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) dut_l (.clk(clk), .rst(rst), .bus(if_l));
    sipo_reg #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) dut_m (.clk(clk), .rst(rst), .bus(if_m));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] po_l, input logic [7:0] po_m,
                             input logic [2:0] cnt, input logic dn);
        check({tag, ".po_l"},  {24'd0, if_l.parallel_out}, {24'd0, po_l});
        check({tag, ".po_m"},  {24'd0, if_m.parallel_out}, {24'd0, po_m});
        check({tag, ".cnt_l"}, {29'd0, if_l.bit_cnt},      {29'd0, cnt});
        check({tag, ".cnt_m"}, {29'd0, if_m.bit_cnt},      {29'd0, cnt});
        check({tag, ".dn_l"},  {31'd0, if_l.word_done},    {31'd0, dn});
        check({tag, ".dn_m"},  {31'd0, if_m.word_done},    {31'd0, dn});
    endtask

    // Drive one cycle: set inputs on the falling edge, advance the model at the rising edge, return 1ns later.
    task automatic step(input logic r, input logic e, input logic b);
        @(negedge clk);
        rst = r;
        en  = e;
        sin = b;
        @(posedge clk);
        if (r) begin
            m_l = 8'h00; m_m = 8'h00; m_cnt = 3'd0; m_dn = 1'b0;
        end else if (e) begin
            m_l = {b, m_l[7:1]};
            m_m = {m_m[6:0], b};
            m_dn  = (m_cnt == 3'd7);
            m_cnt = m_cnt + 3'd1;
        end else begin
            m_dn = 1'b0;
        end
        #1;
    endtask

    initial begin
        logic [7:0] w1;
        logic [7:0] w2;
        logic [7:0] w3;
        w1 = 8'h4D;
        w2 = 8'hA5;
        w3 = 8'h3C;

        // Reset, with en=1 and serial_in=1 presented during the reset cycles.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check_all("reset", 8'h00, 8'h00, 3'd0, 1'b0);

        // Send bits 1,0,1,1,0,0,1,0 continuously.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, w1[i]);
            if (i == 2) check_all("w1_mid", 8'hA0, 8'h05, 3'd3, 1'b0);
            check("w1_done", {31'd0, if_l.word_done}, {31'd0, (i == 7)});
        end
        check_all("w1_full", 8'h4D, 8'hB2, 3'd0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_all("w1_hold", 8'h4D, 8'hB2, 3'd0, 1'b0);

        // Send 3 bits, leave a 5-cycle gap, then send the remaining 5 bits.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, w1[i]);
        for (int g = 0; g < 5; g++) begin
            step(1'b0, 1'b0, g[0]);
            check_all("gap", 8'hA0, 8'h05, 3'd3, 1'b0);
        end
        for (int i = 3; i < 8; i++) begin
            step(1'b0, 1'b1, w1[i]);
            check("gap_done", {31'd0, if_m.word_done}, {31'd0, (i == 7)});
        end
        check_all("gap_full", 8'h4D, 8'hB2, 3'd0, 1'b1);

        // Reset after 4 accepted bits, with en=1 and serial_in=1 in the reset cycle.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
        check("pre_rst_cnt", {29'd0, if_l.bit_cnt}, 32'd4);
        step(1'b1, 1'b1, 1'b1);
        check_all("mid_rst", 8'h00, 8'h00, 3'd0, 1'b0);

        // Send 0xA5 then 0x3C back to back, LSB first; expect one word_done per word.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, (i < 8) ? w2[i] : w3[i-8]);
            check("b2b_done", {31'd0, if_l.word_done}, {31'd0, (i == 7 || i == 15)});
            if (i == 7)  check_all("b2b_w1", 8'hA5, 8'hA5, 3'd0, 1'b1);
            if (i == 15) check_all("b2b_w2", 8'h3C, 8'h3C, 3'd0, 1'b1);
        end

        // Random en and serial_in, with an occasional reset, compared against the reference every cycle.
        for (int c = 0; c < 1000; c++) begin
            step(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            check_all("rand", m_l, m_m, m_cnt, m_dn);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
